// File: rtl/memory_stage_pkg.sv
// rtl/memory_stage_pkg.sv - shared widths, MIPS memory opcodes and MEM-stage decode
package memory_stage_pkg;

  localparam int DWIDTH       = 32;
  localparam int OPCODE_WIDTH = 6;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_LW  = 6'b100011;
  localparam opcode_t OP_SW  = 6'b101011;
  localparam opcode_t OP_LB  = 6'b100000;
  localparam opcode_t OP_LBU = 6'b100100;
  localparam opcode_t OP_LH  = 6'b100001;
  localparam opcode_t OP_LHU = 6'b100101;
  localparam opcode_t OP_SB  = 6'b101000;
  localparam opcode_t OP_SH  = 6'b101001;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  typedef struct packed {
    logic      load;
    logic      store;
    logic      sign;
    logic      no_wb;
    acc_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input opcode_t op);
    mem_op_t d;
    d = '0;
    d.size = SZ_NONE;
    case (op)
      OP_LW:  begin d.load = 1'b1;  d.size = SZ_WORD; end
      OP_SW:  begin d.store = 1'b1; d.size = SZ_WORD; end
`ifdef MEM_BYTE_ACCESS_EN
      OP_LB:  begin d.load = 1'b1;  d.size = SZ_BYTE; d.sign = 1'b1; end
      OP_LBU: begin d.load = 1'b1;  d.size = SZ_BYTE; end
      OP_LH:  begin d.load = 1'b1;  d.size = SZ_HALF; d.sign = 1'b1; end
      OP_LHU: begin d.load = 1'b1;  d.size = SZ_HALF; end
      OP_SB:  begin d.store = 1'b1; d.size = SZ_BYTE; end
      OP_SH:  begin d.store = 1'b1; d.size = SZ_HALF; end
`else
      // Narrow accesses unsupported: pass the ALU value through but never write back.
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH: d.no_wb = 1'b1;
`endif
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// rtl/memory_stage_data_memory.sv - word-addressed data RAM, async read, byte-enabled sync write
module data_memory #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DWIDTH/8-1:0] be,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH-1:0]   wdata,
  output logic [DWIDTH-1:0]   rdata
);

  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DWIDTH/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM stage: load/store, alignment check, MEM/WB register; option MEM_BYTE_ACCESS_EN
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DWIDTH     = memory_stage_pkg::DWIDTH,
  parameter int MEM_AWIDTH = 10,
  parameter int RWIDTH     = 5
) (
  input  logic                    ms_clk,
  input  logic                    ms_rst,
  input  logic                    ms_i_ce,
  input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
  input  logic [DWIDTH-1:0]       ms_i_alu_value,
  input  logic [DWIDTH-1:0]       ms_i_data_rt,
  input  logic [RWIDTH-1:0]       ms_i_rd_addr,
  input  logic                    ms_i_regwrite,
  input  logic                    ms_i_stall,
  input  logic                    ms_i_flush,
  output logic                    ms_o_ce,
  output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
  output logic [DWIDTH-1:0]       ms_o_data,
  output logic [RWIDTH-1:0]       ms_o_rd_addr,
  output logic                    ms_o_regwrite,
  output logic                    ms_o_misaligned
);

  mem_op_t             op;
  logic [1:0]          off;
  logic                misaligned;
  logic                mem_we;
  logic [3:0]          mem_be;
  logic [DWIDTH-1:0]   mem_wdata;
  logic [DWIDTH-1:0]   mem_rdata;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [DWIDTH-1:0]   load_data;
  logic [DWIDTH-1:0]   next_data;
  logic                next_regwrite;

  assign op  = decode_op(ms_i_opcode);
  assign off = ms_i_alu_value[1:0];

  assign misaligned = ms_i_ce & (op.load | op.store) &
                      (((op.size == SZ_WORD) & (off != 2'b00)) |
                       ((op.size == SZ_HALF) & off[0]));

  // A store commits only on an edge where the instruction actually advances into WB.
  assign mem_we = ~ms_rst & ~ms_i_flush & ~ms_i_stall & ms_i_ce & op.store & ~misaligned;

  always_comb begin
    mem_be    = 4'hF;
    mem_wdata = ms_i_data_rt;
    case (op.size)
      SZ_HALF: begin
        mem_be    = off[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{ms_i_data_rt[15:0]}};
      end
      SZ_BYTE: begin
        mem_be    = 4'b0001 << off;
        mem_wdata = {4{ms_i_data_rt[7:0]}};
      end
      default: ;
    endcase
  end

  data_memory #(
    .DWIDTH (DWIDTH),
    .AWIDTH (MEM_AWIDTH)
  ) u_data_memory (
    .clk   (ms_clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (ms_i_alu_value[MEM_AWIDTH+1:2]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign byte_v = mem_rdata[8*off +: 8];
  assign half_v = mem_rdata[16*off[1] +: 16];

  always_comb begin
    load_data = mem_rdata;
    case (op.size)
      SZ_BYTE: load_data = op.sign ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
      SZ_HALF: load_data = op.sign ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
      default: ;
    endcase
  end

  assign next_data     = misaligned ? '0 : (op.load ? load_data : ms_i_alu_value);
  assign next_regwrite = ms_i_regwrite & ~op.store & ~op.no_wb & ~misaligned;

  always_ff @(posedge ms_clk or posedge ms_rst) begin
    if (ms_rst) begin
      ms_o_ce         <= 1'b0;
      ms_o_opcode     <= '0;
      ms_o_data       <= '0;
      ms_o_rd_addr    <= '0;
      ms_o_regwrite   <= 1'b0;
      ms_o_misaligned <= 1'b0;
    end else if (ms_i_flush || (!ms_i_stall && !ms_i_ce)) begin
      ms_o_ce         <= 1'b0;
      ms_o_opcode     <= '0;
      ms_o_data       <= '0;
      ms_o_rd_addr    <= '0;
      ms_o_regwrite   <= 1'b0;
      ms_o_misaligned <= 1'b0;
    end else if (!ms_i_stall) begin
      ms_o_ce         <= 1'b1;
      ms_o_opcode     <= ms_i_opcode;
      ms_o_data       <= next_data;
      ms_o_rd_addr    <= ms_i_rd_addr;
      ms_o_regwrite   <= next_regwrite;
      ms_o_misaligned <= misaligned;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed bench for memory_stage with a byte-array reference model
module tb_memory_stage;

  localparam logic [5:0] LW  = 6'b100011, SW  = 6'b101011, LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] LH  = 6'b100001, LHU = 6'b100101, SB = 6'b101000, SH  = 6'b101001;
  localparam logic [5:0] ADD = 6'b000000;

  logic        ms_clk = 1'b0;
  logic        ms_rst = 1'b1;
  logic        ms_i_ce = 1'b0;
  logic [5:0]  ms_i_opcode = '0;
  logic [31:0] ms_i_alu_value = '0;
  logic [31:0] ms_i_data_rt = '0;
  logic [4:0]  ms_i_rd_addr = '0;
  logic        ms_i_regwrite = 1'b0;
  logic        ms_i_stall = 1'b0;
  logic        ms_i_flush = 1'b0;
  logic        ms_o_ce;
  logic [5:0]  ms_o_opcode;
  logic [31:0] ms_o_data;
  logic [4:0]  ms_o_rd_addr;
  logic        ms_o_regwrite;
  logic        ms_o_misaligned;

  always #5 ms_clk = ~ms_clk;

  memory_stage dut (
    .ms_clk(ms_clk), .ms_rst(ms_rst), .ms_i_ce(ms_i_ce), .ms_i_opcode(ms_i_opcode),
    .ms_i_alu_value(ms_i_alu_value), .ms_i_data_rt(ms_i_data_rt), .ms_i_rd_addr(ms_i_rd_addr),
    .ms_i_regwrite(ms_i_regwrite), .ms_i_stall(ms_i_stall), .ms_i_flush(ms_i_flush),
    .ms_o_ce(ms_o_ce), .ms_o_opcode(ms_o_opcode), .ms_o_data(ms_o_data),
    .ms_o_rd_addr(ms_o_rd_addr), .ms_o_regwrite(ms_o_regwrite), .ms_o_misaligned(ms_o_misaligned)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed 4 KiB memory plus expected WB register contents.
  logic [7:0]  mem_b [0:4095];
  logic        exp_ce = 1'b0, exp_rw = 1'b0, exp_mis = 1'b0;
  logic [5:0]  exp_op = '0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;
  int          m_a;

  function automatic logic [31:0] rd_word(input int a);
    return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
  endfunction

  task automatic model_bubble();
    exp_ce = 0; exp_op = 0; exp_rd = 0; exp_data = 0; exp_rw = 0; exp_mis = 0;
  endtask

  task automatic model_mis();
    exp_mis = 1; exp_rw = 0; exp_data = 0;
  endtask

  always @(posedge ms_clk or posedge ms_rst) begin
    if (ms_rst) model_bubble();
    else if (ms_i_flush) model_bubble();
    else if (ms_i_stall) ;
    else if (!ms_i_ce) model_bubble();
    else begin
      m_a = int'(ms_i_alu_value[11:0]);
      exp_ce = 1; exp_op = ms_i_opcode; exp_rd = ms_i_rd_addr;
      exp_mis = 0; exp_data = ms_i_alu_value; exp_rw = ms_i_regwrite;
      case (ms_i_opcode)
        LW: if (m_a % 4 != 0) model_mis(); else exp_data = rd_word(m_a);
        SW: begin
          exp_rw = 0;
          if (m_a % 4 != 0) model_mis();
          else for (int k = 0; k < 4; k++) mem_b[m_a+k] = ms_i_data_rt[8*k +: 8];
        end
`ifdef MEM_BYTE_ACCESS_EN
        LB:  exp_data = 32'($signed(mem_b[m_a]));
        LBU: exp_data = {24'd0, mem_b[m_a]};
        LH:  if (m_a % 2 != 0) model_mis(); else exp_data = 32'($signed({mem_b[m_a+1], mem_b[m_a]}));
        LHU: if (m_a % 2 != 0) model_mis(); else exp_data = {16'd0, mem_b[m_a+1], mem_b[m_a]};
        SB:  begin exp_rw = 0; mem_b[m_a] = ms_i_data_rt[7:0]; end
        SH:  begin
          exp_rw = 0;
          if (m_a % 2 != 0) model_mis();
          else begin mem_b[m_a] = ms_i_data_rt[7:0]; mem_b[m_a+1] = ms_i_data_rt[15:8]; end
        end
`else
        LB, LBU, LH, LHU, SB, SH: exp_rw = 0;
`endif
        default: ;
      endcase
    end
  end

  always @(negedge ms_clk) begin
    if (chk_en) begin
      chk("model_ce", 32'(ms_o_ce), 32'(exp_ce));
      chk("model_opcode", 32'(ms_o_opcode), 32'(exp_op));
      chk("model_data", ms_o_data, exp_data);
      chk("model_rd", 32'(ms_o_rd_addr), 32'(exp_rd));
      chk("model_regwrite", 32'(ms_o_regwrite), 32'(exp_rw));
      chk("model_misaligned", 32'(ms_o_misaligned), 32'(exp_mis));
    end
  end

  task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                       input logic [4:0] rd, input logic rw, input logic ce = 1'b1,
                       input logic stall = 1'b0, input logic flush = 1'b0);
    ms_i_opcode = op; ms_i_alu_value = alu; ms_i_data_rt = rt; ms_i_rd_addr = rd;
    ms_i_regwrite = rw; ms_i_ce = ce; ms_i_stall = stall; ms_i_flush = flush;
    @(negedge ms_clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ce"}, 32'(ms_o_ce), 0);
    chk({tag, "_opcode"}, 32'(ms_o_opcode), 0);
    chk({tag, "_data"}, ms_o_data, 0);
    chk({tag, "_rd"}, 32'(ms_o_rd_addr), 0);
    chk({tag, "_regwrite"}, 32'(ms_o_regwrite), 0);
    chk({tag, "_misaligned"}, 32'(ms_o_misaligned), 0);
  endtask

  initial begin
    @(negedge ms_clk);
    chk_zero("reset");
    ms_rst = 1'b0;
    chk_en = 1'b1;

    drive(SW, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
    chk("sw_regwrite", 32'(ms_o_regwrite), 0);
    chk("sw_data", ms_o_data, 32'h10);
    drive(LW, 32'h10, 32'h0, 5'd3, 1'b1);
    chk("lw_fwd_data", ms_o_data, 32'hDEADBEEF);
    chk("lw_fwd_rd", 32'(ms_o_rd_addr), 3);
    chk("lw_fwd_regwrite", 32'(ms_o_regwrite), 1);

    drive(ADD, 32'd9, 32'h0, 5'd5, 1'b1);
    chk("add_data", ms_o_data, 9);
    chk("add_regwrite", 32'(ms_o_regwrite), 1);
    drive(ADD, 32'd9, 32'h0, 5'd5, 1'b1, 1'b0);
    chk("bubble_ce", 32'(ms_o_ce), 0);
    chk("bubble_data", ms_o_data, 0);

    drive(LW, 32'h12, 32'h0, 5'd4, 1'b1);
    chk("lw_mis_flag", 32'(ms_o_misaligned), 1);
    chk("lw_mis_regwrite", 32'(ms_o_regwrite), 0);
    chk("lw_mis_data", ms_o_data, 0);
    drive(SW, 32'h13, 32'h12345678, 5'd0, 1'b0);
    chk("sw_mis_flag", 32'(ms_o_misaligned), 1);
    drive(LW, 32'h10, 32'h0, 5'd6, 1'b1);
    chk("sw_mis_mem_kept", ms_o_data, 32'hDEADBEEF);

    drive(SW, 32'h20, 32'h11111111, 5'd0, 1'b0);
    drive(ADD, 32'h55, 32'h0, 5'd7, 1'b1);
    drive(SW, 32'h20, 32'h22222222, 5'd0, 1'b0, 1'b1, 1'b1);
    drive(SW, 32'h20, 32'h22222222, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("stall_hold_data", ms_o_data, 32'h55);
    chk("stall_hold_rd", 32'(ms_o_rd_addr), 7);
    chk("stall_hold_ce", 32'(ms_o_ce), 1);
    drive(SW, 32'h20, 32'h22222222, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_ce", 32'(ms_o_ce), 0);
    chk("flush_data", ms_o_data, 0);
    drive(LW, 32'h20, 32'h0, 5'd8, 1'b1);
    chk("stall_mem_kept", ms_o_data, 32'h11111111);

    drive(SW, 32'h1000_0024, 32'hCAFEF00D, 5'd0, 1'b0);
    drive(LW, 32'h24, 32'h0, 5'd9, 1'b1);
    chk("wrap_data", ms_o_data, 32'hCAFEF00D);

    drive(SW, 32'h20, 32'h0, 5'd0, 1'b0);
    drive(SB, 32'h21, 32'h80, 5'd0, 1'b1);
    drive(LW, 32'h20, 32'h0, 5'd1, 1'b1);
`ifdef MEM_BYTE_ACCESS_EN
    chk("sb_word", ms_o_data, 32'h00008000);
    drive(LB, 32'h21, 32'h0, 5'd2, 1'b1);
    chk("lb_data", ms_o_data, 32'hFFFFFF80);
    drive(LBU, 32'h21, 32'h0, 5'd2, 1'b1);
    chk("lbu_data", ms_o_data, 32'h00000080);
    drive(LH, 32'h20, 32'h0, 5'd2, 1'b1);
    chk("lh_data", ms_o_data, 32'hFFFF8000);
    drive(SH, 32'h23, 32'hBEEF, 5'd0, 1'b0);
    chk("sh_mis_flag", 32'(ms_o_misaligned), 1);
    drive(LHU, 32'h22, 32'h0, 5'd2, 1'b1);
    chk("lhu_data", ms_o_data, 32'h00000000);
`else
    chk("sb_ignored_word", ms_o_data, 32'h00000000);
    drive(LB, 32'h21, 32'h0, 5'd2, 1'b1);
    chk("lb_pass_data", ms_o_data, 32'h21);
    chk("lb_pass_regwrite", 32'(ms_o_regwrite), 0);
    chk("lb_pass_misaligned", 32'(ms_o_misaligned), 0);
`endif

    drive(LW, 32'h10, 32'h0, 5'd3, 1'b1);
    #2 ms_rst = 1'b1;
    #1 chk_zero("async_reset");
    @(negedge ms_clk);
    ms_rst = 1'b0;
    drive(LW, 32'h10, 32'h0, 5'd3, 1'b1);
    chk("mem_survives_reset", ms_o_data, 32'hDEADBEEF);
    drive(ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
